// File: rtl/ps2_scan_rx.sv
// ps2_scan_rx: PS/2 keyboard receiver folding E0/F0 prefixes into held scan/press/extended outputs with a strobe.
module ps2_scan_rx #(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 2047,
  parameter int TO_W       = 11
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       PS2_CLK,
  input  logic       PS2_DATA,
  output logic [7:0] RX_SCAN,
  output logic       RX_PRESSED,
  output logic       RX_EXTENDED,
  output logic       RX_STROBE,
  output logic       RX_ERR
);
  localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
  state_t state_q, state_d;
  logic [1:0] csync_q, dsync_q;
  logic [FW-1:0] fcnt_q;
  logic filt_q, filt_dly_q, fall, din;
  logic [2:0] bitcnt_q, bitcnt_d, skip_q, skip_d;
  logic [7:0] shift_q, shift_d, scan_q, scan_d;
  logic par_q, par_d, ext_q, ext_d, brk_q, brk_d;
  logic pressed_q, pressed_d, extd_q, extd_d, strobe_q, strobe_d, err_q, err_d;
  logic [TO_W-1:0] to_q, to_d;
  logic frame_ok, frame_bad, timeout, is_ctrl;
  assign fall = filt_dly_q & ~filt_q;
  assign din = dsync_q[1];
  assign RX_SCAN = scan_q;
  assign RX_PRESSED = pressed_q;
  assign RX_EXTENDED = extd_q;
  assign RX_STROBE = strobe_q;
  assign RX_ERR = err_q;
  // The filtered clock only moves after FILTER_LEN consecutive disagreeing samples.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      csync_q <= 2'b11;
      dsync_q <= 2'b11;
      fcnt_q <= '0;
      filt_q <= 1'b1;
      filt_dly_q <= 1'b1;
    end else begin
      csync_q <= {csync_q[0], PS2_CLK};
      dsync_q <= {dsync_q[0], PS2_DATA};
      filt_dly_q <= filt_q;
      if (csync_q[1] == filt_q) fcnt_q <= '0;
      else if (fcnt_q == FW'(FILTER_LEN - 1)) begin
        filt_q <= ~filt_q;
        fcnt_q <= '0;
      end else fcnt_q <= fcnt_q + FW'(1);
    end
  end
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= IDLE;
      bitcnt_q <= '0;
      shift_q <= '0;
      par_q <= 1'b0;
      to_q <= '0;
      ext_q <= 1'b0;
      brk_q <= 1'b0;
      skip_q <= '0;
      scan_q <= '0;
      pressed_q <= 1'b0;
      extd_q <= 1'b0;
      strobe_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      bitcnt_q <= bitcnt_d;
      shift_q <= shift_d;
      par_q <= par_d;
      to_q <= to_d;
      ext_q <= ext_d;
      brk_q <= brk_d;
      skip_q <= skip_d;
      scan_q <= scan_d;
      pressed_q <= pressed_d;
      extd_q <= extd_d;
      strobe_q <= strobe_d;
      err_q <= err_d;
    end
  end
  always_comb begin
    state_d = state_q;
    bitcnt_d = bitcnt_q;
    shift_d = shift_q;
    par_d = par_q;
    to_d = (fall || state_q == IDLE) ? '0 : to_q + TO_W'(1);
    frame_ok = 1'b0;
    frame_bad = 1'b0;
    timeout = 1'b0;
    if (fall) begin
      case (state_q)
        IDLE: begin
          state_d = din ? IDLE : DATA;
          bitcnt_d = '0;
        end
        DATA: begin
          shift_d = {din, shift_q[7:1]};
          bitcnt_d = bitcnt_q + 3'd1;
          state_d = (bitcnt_q == 3'd7) ? PARITY : DATA;
        end
        PARITY: begin
          par_d = din;
          state_d = STOP;
        end
        default: begin
          state_d = IDLE;
          frame_ok = din & (^{shift_q, par_q});
          frame_bad = ~frame_ok;
        end
      endcase
    end else if (state_q != IDLE && to_q == TO_W'(TIMEOUT)) begin
      state_d = IDLE;
      timeout = 1'b1;
    end
  end
  // Byte handling is evaluated on the stop-bit fall so outputs land one cycle later.
  always_comb begin
    is_ctrl = shift_q inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF};
    ext_d = frame_bad ? 1'b0 : ext_q;
    brk_d = frame_bad ? 1'b0 : brk_q;
    skip_d = skip_q;
    scan_d = scan_q;
    pressed_d = pressed_q;
    extd_d = extd_q;
    strobe_d = 1'b0;
    err_d = frame_bad | timeout;
    if (frame_ok) begin
      if (skip_q != 3'd0) skip_d = skip_q - 3'd1;
      else if (shift_q == 8'hE1) skip_d = 3'd7;
      else if (shift_q == 8'hE0) ext_d = 1'b1;
      else if (shift_q == 8'hF0) brk_d = 1'b1;
      else if (!is_ctrl) begin
        scan_d = shift_q;
        pressed_d = ~brk_q;
        extd_d = ext_q;
        strobe_d = 1'b1;
        ext_d = 1'b0;
        brk_d = 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_ps2_scan_rx.sv
// tb_ps2_scan_rx: directed frames against ps2_scan_rx with hand-computed expected decodes.
`timescale 1ns/1ps
module tb_ps2_scan_rx;
  logic CLK, RESET_N, PS2_CLK, PS2_DATA;
  logic [7:0] RX_SCAN;
  logic RX_PRESSED, RX_EXTENDED, RX_STROBE, RX_ERR;
  int n_chk = 0, n_fail = 0, n_stb = 0, n_err = 0, s0, e0;
  ps2_scan_rx dut (
    .CLK(CLK), .RESET_N(RESET_N), .PS2_CLK(PS2_CLK), .PS2_DATA(PS2_DATA),
    .RX_SCAN(RX_SCAN), .RX_PRESSED(RX_PRESSED), .RX_EXTENDED(RX_EXTENDED),
    .RX_STROBE(RX_STROBE), .RX_ERR(RX_ERR)
  );
  initial CLK = 1'b0;
  always #320 CLK = ~CLK;
  always @(negedge CLK) begin
    if (RX_STROBE) n_stb++;
    if (RX_ERR) n_err++;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic ps2_bit(input logic b);
    @(negedge CLK);
    PS2_DATA = b;
    repeat (20) @(negedge CLK);
    PS2_CLK = 1'b0;
    repeat (40) @(negedge CLK);
    PS2_CLK = 1'b1;
    repeat (20) @(negedge CLK);
  endtask
  task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic lat);
    logic [10:0] bits;
    bits = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < 10; i++) ps2_bit(bits[i]);
    @(negedge CLK);
    PS2_DATA = 1'b1;
    repeat (20) @(negedge CLK);
    PS2_CLK = 1'b0;
    if (lat) begin
      repeat (10) @(posedge CLK);
      #1 check("lat_early", RX_STROBE, 0);
      @(posedge CLK);
      #1 check("lat_edge", RX_STROBE, 1);
    end
    repeat (40) @(negedge CLK);
    PS2_CLK = 1'b1;
    repeat (20) @(negedge CLK);
  endtask
  task automatic expect_out(input string tag, input logic [7:0] sc, input logic pr, input logic ex);
    check({tag, "_scan"}, RX_SCAN, sc);
    check({tag, "_pressed"}, RX_PRESSED, pr);
    check({tag, "_ext"}, RX_EXTENDED, ex);
  endtask
  initial begin
    RESET_N = 1'b0;
    PS2_CLK = 1'b1;
    PS2_DATA = 1'b1;
    repeat (5) @(negedge CLK);
    expect_out("rst", 8'h00, 0, 0);
    check("rst_strobe", RX_STROBE, 0);
    check("rst_err", RX_ERR, 0);
    RESET_N = 1'b1;
    repeat (20) @(negedge CLK);
    s0 = n_stb; e0 = n_err;
    send_frame(8'h1C, 0, 1);
    expect_out("make_a", 8'h1C, 1, 0);
    check("make_a_stb", n_stb - s0, 1);
    check("make_a_err", n_err - e0, 0);
    s0 = n_stb;
    send_frame(8'hE0, 0, 0);
    send_frame(8'hF0, 0, 0);
    send_frame(8'h6B, 0, 0);
    expect_out("ext_brk", 8'h6B, 0, 1);
    check("ext_brk_stb", n_stb - s0, 1);
    send_frame(8'h6B, 0, 0);
    expect_out("after_ext", 8'h6B, 1, 0);
    s0 = n_stb; e0 = n_err;
    send_frame(8'hF0, 0, 0);
    send_frame(8'h1C, 1, 0);
    check("par_err", n_err - e0, 1);
    check("par_stb", n_stb - s0, 0);
    check("par_hold", RX_SCAN, 8'h6B);
    send_frame(8'h07, 0, 0);
    expect_out("after_par", 8'h07, 1, 0);
    s0 = n_stb; e0 = n_err;
    PS2_DATA = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK) PS2_CLK = 1'b0;
      repeat (3) @(negedge CLK);
      PS2_CLK = 1'b1;
      repeat (5) @(negedge CLK);
    end
    PS2_DATA = 1'b1;
    repeat (30) @(negedge CLK);
    send_frame(8'h76, 0, 0);
    expect_out("glitch", 8'h76, 1, 0);
    check("glitch_err", n_err - e0, 0);
    ps2_bit(0);
    ps2_bit(1); ps2_bit(0); ps2_bit(1); ps2_bit(1);
    e0 = n_err;
    repeat (1900) @(negedge CLK);
    check("to_early", n_err - e0, 0);
    repeat (300) @(negedge CLK);
    check("to_err", n_err - e0, 1);
    s0 = n_stb;
    send_frame(8'h4B, 0, 0);
    expect_out("after_to", 8'h4B, 1, 0);
    check("after_to_stb", n_stb - s0, 1);
    s0 = n_stb;
    send_frame(8'hE1, 0, 0); send_frame(8'h14, 0, 0); send_frame(8'h77, 0, 0);
    send_frame(8'hE1, 0, 0); send_frame(8'hF0, 0, 0); send_frame(8'h14, 0, 0);
    send_frame(8'hF0, 0, 0); send_frame(8'h77, 0, 0);
    check("pause_stb", n_stb - s0, 0);
    send_frame(8'h05, 0, 0);
    expect_out("pause", 8'h05, 1, 0);
    check("pause_total", n_stb - s0, 1);
    s0 = n_stb;
    send_frame(8'hFA, 0, 0);
    send_frame(8'hAA, 0, 0);
    check("ctrl_stb", n_stb - s0, 0);
    check("ctrl_hold", RX_SCAN, 8'h05);
    ps2_bit(0);
    ps2_bit(1); ps2_bit(1); ps2_bit(0); ps2_bit(0);
    RESET_N = 1'b0;
    #1 expect_out("midrst", 8'h00, 0, 0);
    check("midrst_strobe", RX_STROBE, 0);
    repeat (5) @(negedge CLK);
    RESET_N = 1'b1;
    repeat (20) @(negedge CLK);
    s0 = n_stb;
    send_frame(8'h29, 0, 0);
    expect_out("post_rst", 8'h29, 1, 0);
    check("post_rst_stb", n_stb - s0, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
